// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder
//   Monitors the multiplexed seven-segment lines and rebuilds the four hex
//   digits and dot points that are on the display. A digit set is published
//   only after it has repeated for STABLE_FRAMES complete scan frames.
//
// Ports
//   board_clk     in   system clock
//   Reset_Pulse   in   asynchronous active-high reset
//   An[3:0]       in   anodes {An3..An0}, active-low, An3 = leftmost digit
//   Cath[7:0]     in   {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low
//   digits[15:0]  out  published nibbles {d3,d2,d1,d0}
//   dp[3:0]       out  published dot points, 1 = lit
//   digits_valid  out  high while locked
//   frame_pulse   out  one-cycle strobe on every (re)publish
//   pattern_err   out  sticky: accepted segment pattern is not a hex glyph
//   anode_err     out  sticky: accepted sample had several anodes low
module ssd_scan_decoder #(
  parameter int SETTLE_CYC    = 4,
  parameter int STABLE_FRAMES = 2,
  parameter int TIMEOUT_CYC   = 1048576
) (
  input  logic        board_clk,
  input  logic        Reset_Pulse,
  input  logic [3:0]  An,
  input  logic [7:0]  Cath,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic        digits_valid,
  output logic        frame_pulse,
  output logic        pattern_err,
  output logic        anode_err
);

  localparam int SW = $clog2(SETTLE_CYC) + 1;
  localparam int MW = $clog2(STABLE_FRAMES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t      state_reg, state_next;

  logic [3:0]  an_s1, an_s2, an_prev;
  logic [7:0]  cath_s1, cath_s2, cath_prev;
  logic [SW-1:0] settle_cnt_reg;
  logic [MW-1:0] match_cnt_reg, match_next;
  logic [TW-1:0] idle_cnt_reg;

  logic [15:0] scratch_reg;
  logic [3:0]  scr_dp_reg;
  logic [3:0]  seen_reg, seen_next;
  logic [19:0] last_frame_reg;
  logic        captured_reg;

  logic        same, accept, blank, single;
  logic [1:0]  idx;
  logic        dec_hit;
  logic [3:0]  dec_nib;
  logic        capture, miss, multi;
  logic        frame_check, frame_equal, reach, timeout, publish;
  logic [19:0] new_frame;

  // Settle filter: a sample is accepted once, on the step into saturation.
  assign same   = ({an_s2, cath_s2} == {an_prev, cath_prev});
  assign accept = same && (settle_cnt_reg == SW'(SETTLE_CYC - 1));

  always_comb begin
    single = 1'b1;
    idx    = 2'd0;
    blank  = (an_s2 == 4'b1111);
    case (an_s2)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: single = 1'b0;
    endcase
  end

  // Inverse of the driver's segment table (abcdefg, active-low).
  always_comb begin
    dec_hit = 1'b1;
    dec_nib = 4'h0;
    case (cath_s2[7:1])
      7'b0000001: dec_nib = 4'h0;
      7'b1001111: dec_nib = 4'h1;
      7'b0010010: dec_nib = 4'h2;
      7'b0000110: dec_nib = 4'h3;
      7'b1001100: dec_nib = 4'h4;
      7'b0100100: dec_nib = 4'h5;
      7'b0100000: dec_nib = 4'h6;
      7'b0001111: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0000100: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b1100000: dec_nib = 4'hB;
      7'b0110001: dec_nib = 4'hC;
      7'b1000010: dec_nib = 4'hD;
      7'b0110000: dec_nib = 4'hE;
      7'b0111000: dec_nib = 4'hF;
      default:    dec_hit = 1'b0;
    endcase
  end

  assign capture = accept && single && dec_hit;
  assign miss    = accept && single && !dec_hit;
  assign multi   = accept && !blank && !single;

  // Frame bookkeeping runs the cycle after a capture so seen already
  // includes the digit just written.
  assign new_frame   = {scratch_reg, scr_dp_reg};
  assign frame_check = captured_reg && (seen_reg == 4'b1111);
  assign frame_equal = (new_frame == last_frame_reg);
  assign timeout     = (idle_cnt_reg == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    if (!frame_equal)
      match_next = MW'(1);
    else if (match_cnt_reg == MW'(STABLE_FRAMES))
      match_next = match_cnt_reg;
    else
      match_next = match_cnt_reg + MW'(1);
  end

  // Only the step onto the threshold publishes; a saturated repeat does not.
  assign reach = frame_check && (match_next == MW'(STABLE_FRAMES)) &&
                 !(frame_equal && (match_cnt_reg == MW'(STABLE_FRAMES)));

  always_comb begin
    seen_next = (timeout || frame_check) ? 4'b0000 : seen_reg;
    if (capture)
      seen_next[idx] = 1'b1;
    else if (miss)
      seen_next[idx] = 1'b0;
  end

  always_comb begin
    state_next = state_reg;
    publish    = 1'b0;
    if (timeout) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (capture) state_next = ACQUIRE;
        ACQUIRE: if (reach) begin
                   state_next = LOCKED;
                   publish    = 1'b1;
                 end
        LOCKED:  if (reach) publish = 1'b1;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge board_clk or posedge Reset_Pulse) begin
    if (Reset_Pulse) begin
      state_reg      <= IDLE;
      an_s1          <= 4'h0;
      an_s2          <= 4'h0;
      an_prev        <= 4'h0;
      cath_s1        <= 8'h00;
      cath_s2        <= 8'h00;
      cath_prev      <= 8'h00;
      settle_cnt_reg <= '0;
      match_cnt_reg  <= '0;
      idle_cnt_reg   <= '0;
      scratch_reg    <= 16'h0000;
      scr_dp_reg     <= 4'h0;
      seen_reg       <= 4'h0;
      last_frame_reg <= 20'h00000;
      captured_reg   <= 1'b0;
      digits         <= 16'h0000;
      dp             <= 4'h0;
      digits_valid   <= 1'b0;
      frame_pulse    <= 1'b0;
      pattern_err    <= 1'b0;
      anode_err      <= 1'b0;
    end else begin
      state_reg <= state_next;
      an_s1     <= An;
      an_s2     <= an_s1;
      an_prev   <= an_s2;
      cath_s1   <= Cath;
      cath_s2   <= cath_s1;
      cath_prev <= cath_s2;

      if (!same)
        settle_cnt_reg <= '0;
      else if (settle_cnt_reg != SW'(SETTLE_CYC))
        settle_cnt_reg <= settle_cnt_reg + SW'(1);

      // A miss counts as display activity, so it also holds off the timeout.
      if (timeout || capture || miss)
        idle_cnt_reg <= '0;
      else
        idle_cnt_reg <= idle_cnt_reg + TW'(1);

      if (capture) begin
        scratch_reg[idx*4 +: 4] <= dec_nib;
        scr_dp_reg[idx]         <= ~cath_s2[0];
      end
      seen_reg     <= seen_next;
      captured_reg <= capture;

      if (timeout)
        match_cnt_reg <= '0;
      else if (frame_check)
        match_cnt_reg <= match_next;

      if (frame_check && !frame_equal)
        last_frame_reg <= new_frame;

      if (miss)  pattern_err <= 1'b1;
      if (multi) anode_err   <= 1'b1;

      frame_pulse  <= publish;
      digits_valid <= (state_next == LOCKED);
      if (publish) begin
        digits <= new_frame[19:4];
        dp     <= new_frame[3:0];
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb_ssd_scan_decoder
//   Directed scans of the display lines with hand-computed expectations for
//   the published digits, dot points, strobes and sticky error flags.
module tb_ssd_scan_decoder;

  localparam int SETTLE  = 4;
  localparam int STABLE  = 2;
  localparam int TIMEOUT = 2048;
  localparam int DIG_CYC = 64;

  logic        board_clk = 1'b0;
  logic        Reset_Pulse = 1'b1;
  logic [3:0]  An = 4'b1111;
  logic [7:0]  Cath = 8'hFF;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        digits_valid, frame_pulse, pattern_err, anode_err;

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;
  int pc0;

  ssd_scan_decoder #(
    .SETTLE_CYC   (SETTLE),
    .STABLE_FRAMES(STABLE),
    .TIMEOUT_CYC  (TIMEOUT)
  ) dut (
    .board_clk   (board_clk),
    .Reset_Pulse (Reset_Pulse),
    .An          (An),
    .Cath        (Cath),
    .digits      (digits),
    .dp          (dp),
    .digits_valid(digits_valid),
    .frame_pulse (frame_pulse),
    .pattern_err (pattern_err),
    .anode_err   (anode_err)
  );

  always #5 board_clk = ~board_clk;

  always @(posedge board_clk or posedge Reset_Pulse)
    if (!Reset_Pulse && frame_pulse) pulse_cnt <= pulse_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'b0000001;  4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;  4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;  4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;  4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;  4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;  4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;  default: seg = 7'b0111000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic do_reset();
    Reset_Pulse = 1'b1;
    An = 4'b1111;
    Cath = 8'hFF;
    repeat (3) @(negedge board_clk);
    Reset_Pulse = 1'b0;
    @(negedge board_clk);
  endtask

  // Scan ndig digit windows starting at An3; optional 2-cycle all-on glitch
  // at the start of each window.
  task automatic scan(input logic [15:0] d, input logic [3:0] p, input int ndig, input bit glitch);
    for (int k = 0; k < ndig; k++) begin
      int i;
      logic [3:0] one;
      i = 3 - (k % 4);
      one = 4'b0001 << i;
      for (int c = 0; c < DIG_CYC; c++) begin
        @(negedge board_clk);
        An = ~one;
        if (glitch && c < 2) Cath = 8'h00;
        else                 Cath = {seg(d[i*4 +: 4]), ~p[i]};
      end
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [7:0] c, input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge board_clk);
      An = a;
      Cath = c;
    end
  endtask

  initial begin
    // Test 1: plain scan of 1,2,3,4
    do_reset();
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_flags", 32'({dp, digits_valid, frame_pulse, pattern_err, anode_err}), 32'h0);
    pc0 = pulse_cnt;
    scan(16'h1234, 4'b0000, 4, 1'b0);
    check("t1_f1_pulses", 32'(pulse_cnt - pc0), 32'd0);
    check("t1_f1_valid", 32'(digits_valid), 32'd0);
    scan(16'h1234, 4'b0000, 4, 1'b0);
    check("t1_f2_pulses", 32'(pulse_cnt - pc0), 32'd1);
    scan(16'h1234, 4'b0000, 4, 1'b0);
    check("t1_f3_pulses", 32'(pulse_cnt - pc0), 32'd1);
    check("t1_digits", 32'(digits), 32'h1234);
    check("t1_dp", 32'(dp), 32'h0);
    check("t1_valid", 32'(digits_valid), 32'd1);

    // Test 2: dot point on An1, then digit 0 changes to F
    do_reset();
    pc0 = pulse_cnt;
    scan(16'h1234, 4'b0010, 8, 1'b0);
    check("t2_pulses", 32'(pulse_cnt - pc0), 32'd1);
    check("t2_dp", 32'(dp), 32'h2);
    check("t2_digits", 32'(digits), 32'h1234);
    scan(16'h123F, 4'b0010, 4, 1'b0);
    check("t2_chg1_pulses", 32'(pulse_cnt - pc0), 32'd1);
    check("t2_chg1_digits", 32'(digits), 32'h1234);
    scan(16'h123F, 4'b0010, 4, 1'b0);
    check("t2_chg2_pulses", 32'(pulse_cnt - pc0), 32'd2);
    check("t2_chg2_digits", 32'(digits), 32'h123F);
    check("t2_chg2_dp", 32'(dp), 32'h2);

    // Test 3: short glitches at every anode edge are filtered out
    do_reset();
    pc0 = pulse_cnt;
    scan(16'h1234, 4'b0000, 12, 1'b1);
    check("t3_pulses", 32'(pulse_cnt - pc0), 32'd1);
    check("t3_digits", 32'(digits), 32'h1234);
    check("t3_dp", 32'(dp), 32'h0);
    check("t3_perr", 32'(pattern_err), 32'd0);
    check("t3_valid", 32'(digits_valid), 32'd1);

    // Test 4: unknown segment pattern
    pc0 = pulse_cnt;
    hold(4'b1110, 8'hFF, 10);
    check("t4_perr", 32'(pattern_err), 32'd1);
    check("t4_pulses", 32'(pulse_cnt - pc0), 32'd0);
    check("t4_valid", 32'(digits_valid), 32'd1);
    check("t4_aerr", 32'(anode_err), 32'd0);

    // Test 5: two anodes low, then blank until the lock times out
    hold(4'b0011, {seg(4'h5), 1'b1}, 10);
    check("t5_aerr", 32'(anode_err), 32'd1);
    check("t5_digits_pre", 32'(digits), 32'h1234);
    check("t5_valid_pre", 32'(digits_valid), 32'd1);
    hold(4'b1111, 8'hFF, TIMEOUT);
    check("t5_valid_post", 32'(digits_valid), 32'd0);
    check("t5_digits_hold", 32'(digits), 32'h1234);
    check("t5_sticky", 32'({pattern_err, anode_err}), 32'h3);

    // Test 6: relock, then reset in the middle of a frame
    pc0 = pulse_cnt;
    scan(16'h1234, 4'b0100, 8, 1'b0);
    check("t6_relock_pulses", 32'(pulse_cnt - pc0), 32'd1);
    check("t6_relock_dp", 32'(dp), 32'h4);
    check("t6_relock_valid", 32'(digits_valid), 32'd1);
    scan(16'h1234, 4'b0100, 2, 1'b0);
    #2;
    Reset_Pulse = 1'b1;
    #1;
    check("t6_rst_digits", 32'(digits), 32'h0);
    check("t6_rst_flags", 32'({dp, digits_valid, frame_pulse, pattern_err, anode_err}), 32'h0);
    @(negedge board_clk);
    An = 4'b1111;
    Cath = 8'hFF;
    @(negedge board_clk);
    Reset_Pulse = 1'b0;
    pc0 = pulse_cnt;
    scan(16'h1234, 4'b0000, 4, 1'b0);
    check("t6_f1_pulses", 32'(pulse_cnt - pc0), 32'd0);
    scan(16'h1234, 4'b0000, 4, 1'b0);
    check("t6_f2_pulses", 32'(pulse_cnt - pc0), 32'd1);
    check("t6_digits", 32'(digits), 32'h1234);
    check("t6_valid", 32'(digits_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
